ysyx_24070003_btb_upd_ctrl: RTL and testbench

Scheduler for the branch-target-buffer update port. It accepts resolved branches from the EXU through a valid/ready handshake and keeps only taken, mispredicted ones. These are buffered in a small FIFO, with back-to-back duplicate PCs merged. Entries drain to the BTB one per cycle whenever the IFU is not looking up the BTB; a starvation counter forces a write if the IFU keeps it busy too long. fence.i flushes the queue and pulses a BTB clear.

---
 rtl/ysyx_24070003_btb_upd_ctrl_pkg.sv | 19 +
 rtl/ysyx_24070003_btb_upd_ctrl_if.sv | 38 +++
 rtl/ysyx_24070003_btb_upd_fifo.sv | 59 +++++
 rtl/ysyx_24070003_btb_upd_ctrl.sv | 104 ++++++++++
 tb/tb_ysyx_24070003_btb_upd_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24070003_btb_upd_ctrl_pkg.sv
// Shared types for the BTB update scheduler: FSM encoding, BTB geometry, queue entry.
package ysyx_24070003_btb_upd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } btb_upd_state_t;

    // BTB geometry: PC[1:0] is the instruction offset, the next 2 bits index the BTB.
    localparam int BTB_OFF_W = 2;
    localparam int BTB_IDX_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/ysyx_24070003_btb_upd_ctrl_if.sv
// EXU/IFU/BTB-side signal bundle of the BTB update scheduler.
interface ysyx_24070003_btb_upd_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          exu_valid;
    logic          exu_ready;
    logic [31:0]   exu_pc;
    logic [31:0]   exu_target;
    logic          exu_taken;
    logic          exu_mispred;
    logic          ifu_lookup;
    logic          fence_i;
    logic          btb_update_valid;
    logic [31:0]   btb_update_pc;
    logic [31:0]   btb_target_pc;
    logic          btb_clear;
    logic [CW-1:0] q_count;
    logic          busy;

    // Driver side (EXU/IFU models, testbench)
    modport master (
        output exu_valid, exu_pc, exu_target, exu_taken, exu_mispred,
        output ifu_lookup, fence_i,
        input  exu_ready, btb_update_valid, btb_update_pc, btb_target_pc,
        input  btb_clear, q_count, busy
    );

    // Scheduler side
    modport slave (
        input  exu_valid, exu_pc, exu_target, exu_taken, exu_mispred,
        input  ifu_lookup, fence_i,
        output exu_ready, btb_update_valid, btb_update_pc, btb_target_pc,
        output btb_clear, q_count, busy
    );

endinterface

// File: rtl/ysyx_24070003_btb_upd_fifo.sv
// Circular buffer of pending BTB writes with an in-place target rewrite of the tail entry.
module ysyx_24070003_btb_upd_fifo
    import ysyx_24070003_btb_upd_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_push,
    input  btb_entry_t  i_push_data,
    input  logic        i_merge,
    input  logic [31:0] i_merge_target,
    input  logic        i_pop,
    output btb_entry_t  o_head,
    output btb_entry_t  o_tail,
    output logic [CW-1:0] o_count
);

    btb_entry_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_tail_ptr;

    assign w_tail_ptr = r_wr_ptr - AW'(1);

    // Pointer and occupancy bookkeeping; clear and reset both empty the queue.
    always_ff @(posedge clock) begin
        if (!reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clock) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_push_data;
        else if (i_merge)
            r_mem[w_tail_ptr].target <= i_merge_target;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_tail  = r_mem[w_tail_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ysyx_24070003_btb_upd_ctrl.sv
// BTB update scheduler: filters resolved branches from the EXU, queues mispredicted
// taken ones, and drains them to the BTB around IFU lookups with a starvation override.
module ysyx_24070003_btb_upd_ctrl
    import ysyx_24070003_btb_upd_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                          clock,
    input logic                          reset,
    ysyx_24070003_btb_upd_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [SW-1:0] L_LIMIT = SW'(STARVE_LIMIT);

    btb_upd_state_t r_state;
    logic [SW-1:0]  r_starve;

    btb_entry_t    w_head;
    btb_entry_t    w_tail;
    btb_entry_t    w_push_data;
    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_ready;
    logic          w_starved;
    logic          w_upd;
    logic          w_qual;
    logic          w_tail_hit;
    logic          w_merge;
    logic          w_push;
    logic          w_blocked;

    assign w_empty     = (w_count == '0);
    assign w_ready     = reset && !bus.fence_i && (r_state != ST_FLUSH) && (w_count < L_DEPTH);
    assign w_starved   = (r_starve == L_LIMIT);
    // Strobe is gated by reset so nothing is written in a reset cycle.
    assign w_upd       = reset && (r_state == ST_DRAIN) && !w_empty
                         && (!bus.ifu_lookup || w_starved);
    assign w_blocked   = (r_state == ST_DRAIN) && !w_empty && bus.ifu_lookup && !w_starved;
    assign w_qual      = bus.exu_valid && w_ready && bus.exu_taken && bus.exu_mispred;
    // A tail that is also the head being popped is gone after this edge, so it cannot absorb a merge.
    assign w_tail_hit  = !w_empty && (w_tail.pc == bus.exu_pc)
                         && !(w_upd && (w_count == CW'(1)));
    assign w_merge     = w_qual && w_tail_hit;
    assign w_push      = w_qual && !w_tail_hit;
    assign w_push_data = '{pc: bus.exu_pc, target: bus.exu_target};

    ysyx_24070003_btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock          (clock),
        .reset          (reset),
        .i_clear        (bus.fence_i),
        .i_push         (w_push),
        .i_push_data    (w_push_data),
        .i_merge        (w_merge),
        .i_merge_target (bus.exu_target),
        .i_pop          (w_upd),
        .o_head         (w_head),
        .o_tail         (w_tail),
        .o_count        (w_count)
    );

    // Scheduler FSM and starvation counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_starve <= '0;
        end else if (bus.fence_i) begin
            r_state  <= ST_FLUSH;
            r_starve <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_starve <= '0;
                    if (w_push) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_upd)
                        r_starve <= '0;
                    else if (w_blocked)
                        r_starve <= r_starve + SW'(1);
                    if (w_upd && (w_count == CW'(1)) && !w_push)
                        r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_starve <= '0;
                end
            endcase
        end
    end

    assign bus.exu_ready        = w_ready;
    assign bus.btb_update_valid = w_upd;
    assign bus.btb_update_pc    = w_empty ? 32'h0 : w_head.pc;
    assign bus.btb_target_pc    = w_empty ? 32'h0 : w_head.target;
    assign bus.btb_clear        = (r_state == ST_FLUSH);
    assign bus.q_count          = w_count;
    assign bus.busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_24070003_btb_upd_ctrl.sv
// Directed plus randomized bench for the BTB update scheduler against a queue-level model.
module tb_ysyx_24070003_btb_upd_ctrl;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_24070003_btb_upd_ctrl_if #(.DEPTH(DEPTH)) bus ();

    ysyx_24070003_btb_upd_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    ent_t m_q[$];
    bit   m_drain;
    bit   m_flush;
    int   m_starve;
    int   n_checks;
    int   n_err;
    int   cyc;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit v, logic [31:0] pc, logic [31:0] tg, bit tk, bit mp, bit lk, bit fn);
        bus.exu_valid   = v;
        bus.exu_pc      = pc;
        bus.exu_target  = tg;
        bus.exu_taken   = tk;
        bus.exu_mispred = mp;
        bus.ifu_lookup  = lk;
        bus.fence_i     = fn;
    endtask

    // Check all outputs against the model for the current cycle, advance the model, then one clock.
    task automatic step();
        bit          e_rdy, e_vld, hs_q, mrg;
        logic [31:0] e_pc, e_tg;
        #1;
        e_rdy = reset && !bus.fence_i && !m_flush && (m_q.size() < DEPTH);
        e_vld = reset && m_drain && (m_q.size() > 0) && (!bus.ifu_lookup || m_starve == LIMIT);
        e_pc  = (m_q.size() > 0) ? m_q[0].pc : 32'h0;
        e_tg  = (m_q.size() > 0) ? m_q[0].target : 32'h0;
        chk("exu_ready", 32'(bus.exu_ready), 32'(e_rdy));
        chk("upd_valid", 32'(bus.btb_update_valid), 32'(e_vld));
        chk("upd_pc", bus.btb_update_pc, e_pc);
        chk("upd_target", bus.btb_target_pc, e_tg);
        chk("btb_clear", 32'(bus.btb_clear), 32'(m_flush));
        chk("q_count", 32'(bus.q_count), 32'(m_q.size()));
        chk("busy", 32'(bus.busy), 32'(m_drain || m_flush));

        hs_q = bus.exu_valid && e_rdy && bus.exu_taken && bus.exu_mispred;
        if (!reset) begin
            m_q.delete();
            m_drain = 0; m_flush = 0; m_starve = 0;
        end else if (bus.fence_i) begin
            m_q.delete();
            m_drain = 0; m_flush = 1; m_starve = 0;
        end else begin
            mrg = hs_q && (m_q.size() > 0) && (m_q[m_q.size()-1].pc == bus.exu_pc)
                  && !(e_vld && m_q.size() == 1);
            if (e_vld) begin
                void'(m_q.pop_front());
                m_starve = 0;
            end else if (m_drain && m_q.size() > 0 && bus.ifu_lookup && m_starve < LIMIT) begin
                m_starve++;
            end
            if (mrg)
                m_q[m_q.size()-1].target = bus.exu_target;
            else if (hs_q)
                m_q.push_back('{pc: bus.exu_pc, target: bus.exu_target});
            m_flush = 0;
            m_drain = (m_q.size() > 0);
        end
        cyc++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(bit lk, int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 32'h0, 32'h0, 0, 0, lk, 0);
            step();
        end
    endtask

    initial begin
        int first_wr;
        n_checks = 0; n_err = 0; cyc = 0;
        m_drain = 0; m_flush = 0; m_starve = 0;
        reset = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        @(negedge clock);
        step();
        step();
        reset = 1'b1;

        // Single qualifying push drains one cycle later, then the block goes idle.
        drive(1, 32'h80000010, 32'h80000100, 1, 1, 0, 0);
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        #1;
        chk("t1_strobe", 32'(bus.btb_update_valid), 32'd1);
        chk("t1_pc", bus.btb_update_pc, 32'h80000010);
        chk("t1_target", bus.btb_target_pc, 32'h80000100);
        step();
        #1;
        chk("t1_count", 32'(bus.q_count), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        step();

        // Not-taken branch is accepted and dropped.
        drive(1, 32'h80000014, 32'h80000400, 0, 1, 0, 0);
        #1;
        chk("t2_ready", 32'(bus.exu_ready), 32'd1);
        step();
        idle(0, 2);

        // Fill under continuous lookup; the fifth push is refused; starvation forces a write.
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h80001000 + 32'(i * 16), 32'h90000000 + 32'(i), 1, 1, 1, 0);
            if (i == 4) begin
                #1;
                chk("t3_full_ready", 32'(bus.exu_ready), 32'd0);
            end
            step();
        end
        first_wr = -1;
        while (first_wr < 0 && cyc < 30) begin
            drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
            #1;
            if (bus.btb_update_valid) first_wr = cyc;
            step();
        end
        chk("t3_first_forced", 32'(first_wr), 32'd9);
        idle(0, 6);

        // Back-to-back duplicate PC merges into one entry.
        drive(1, 32'h80000020, 32'h80000200, 1, 1, 1, 0);
        step();
        drive(1, 32'h80000020, 32'h80000300, 1, 1, 1, 0);
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        #1;
        chk("t4_count", 32'(bus.q_count), 32'd1);
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        #1;
        chk("t4_strobe", 32'(bus.btb_update_valid), 32'd1);
        chk("t4_target", bus.btb_target_pc, 32'h80000300);
        step();
        idle(0, 2);

        // fence_i with a push pending flushes three entries.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h80002000 + 32'(i * 4), 32'ha0000000 + 32'(i), 1, 1, 1, 0);
            step();
        end
        drive(1, 32'h80003000, 32'hb0000000, 1, 1, 1, 1);
        #1;
        chk("t5_ready", 32'(bus.exu_ready), 32'd0);
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 1, 0);
        #1;
        chk("t5_clear", 32'(bus.btb_clear), 32'd1);
        chk("t5_strobe", 32'(bus.btb_update_valid), 32'd0);
        chk("t5_count", 32'(bus.q_count), 32'd0);
        step();
        #1;
        chk("t5_idle", 32'(bus.busy), 32'd0);
        step();
        // fence_i held two cycles gives two FLUSH cycles.
        drive(0, 32'h0, 32'h0, 0, 0, 0, 1);
        step();
        step();
        idle(0, 2);

        // Reset in the middle of a drain discards everything.
        drive(1, 32'h80004000, 32'hc0000000, 1, 1, 1, 0);
        step();
        drive(1, 32'h80004004, 32'hc0000004, 1, 1, 1, 0);
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("t6_no_strobe", 32'(bus.btb_update_valid), 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("t6_count", 32'(bus.q_count), 32'd0);
        chk("t6_pc", bus.btb_update_pc, 32'h0);
        step();
        idle(0, 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 9) < 7),
                  32'h80000000 + 32'($urandom_range(0, 3) * 4),
                  $urandom,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 3));
            reset = ($urandom_range(0, 99) != 0);
            step();
        end
        reset = 1'b1;
        idle(0, 12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
